// File: rtl/mdbus_front.sv
// ============================================================================
// Module   : mdbus_front
// Purpose  : Mega Drive cartridge-bus front end. Synchronises and filters the
//            raw strobes, then issues single-cycle read/write requests.
// Option   : define MDBUS_STAT_EN to add saturating request counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdbus_front #(
  parameter int AW     = 23,
  parameter int FILT   = 2,
  parameter int WMERGE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] bus_addr,
  input  logic [15:0]   bus_data,
  input  logic          ce_lo_n,
  input  logic          ce_hi_n,
  input  logic          oe_n,
  input  logic          as_n,
  input  logic          we_lo_n,
  input  logic          we_hi_n,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  output logic          rd_hi,
  output logic          wr_req,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic [1:0]    wr_be,
  output logic          bus_busy,
  output logic          bus_err
`ifdef MDBUS_STAT_EN
  ,
  output logic [15:0]   stat_rd,
  output logic [15:0]   stat_wr
`endif
);

  localparam int NS = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ACT   = 2'd1,
    WR_MERGE = 2'd2,
    WR_ACT   = 2'd3
  } state_t;

  logic [NS-1:0] strb_raw;
  logic [NS-1:0] strb_s1_q, strb_s2_q;
  logic [NS-1:0] strb_f;
  logic [AW-1:0] addr_s1_q, addr_s2_q;
  logic [15:0]   data_s1_q, data_s2_q;

  assign strb_raw = {we_hi_n, we_lo_n, as_n, oe_n, ce_hi_n, ce_lo_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_s1_q <= '1;
      strb_s2_q <= '1;
      addr_s1_q <= '0;
      addr_s2_q <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      strb_s1_q <= strb_raw;
      strb_s2_q <= strb_s1_q;
      addr_s1_q <= bus_addr;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= bus_data;
      data_s2_q <= data_s1_q;
    end
  end

  // The current synchronised sample counts toward FILT, so FILT=1 is a pure
  // pass-through and a one-cycle glitch never reaches the FSM when FILT>=2.
  for (genvar gi = 0; gi < NS; gi++) begin : g_filt
    logic [2:0] cnt_q;
    logic       flt_q;
    logic       diff;
    logic       done;

    assign diff       = strb_s2_q[gi] != flt_q;
    assign done       = diff && (cnt_q == 3'(FILT - 1));
    assign strb_f[gi] = done ? strb_s2_q[gi] : flt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        flt_q <= 1'b1;
      end else if (!diff) begin
        cnt_q <= '0;
      end else if (done) begin
        cnt_q <= '0;
        flt_q <= strb_s2_q[gi];
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  logic ce_lo, ce_hi, oe, as_a, we_lo, we_hi;
  logic cs, rdc, wrc;

  assign ce_lo = ~strb_f[0];
  assign ce_hi = ~strb_f[1];
  assign oe    = ~strb_f[2];
  assign as_a  = ~strb_f[3];
  assign we_lo = ~strb_f[4];
  assign we_hi = ~strb_f[5];
  assign cs    = ce_lo | ce_hi;
  assign rdc   = cs & oe;
  assign wrc   = as_a & (we_lo | we_hi);

  state_t        state_q, state_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_hi_q, rd_hi_d;
  logic          wr_req_q, wr_req_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]   wr_data_q, wr_data_d;
  logic [1:0]    wr_be_q, wr_be_d;
  logic [3:0]    mcnt_q, mcnt_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_hi_d   = rd_hi_q;
    wr_req_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    mcnt_d    = mcnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (wrc) begin
          wr_addr_d = addr_s2_q;
          wr_data_d = data_s2_q;
          wr_be_d   = {we_hi, we_lo};
          mcnt_d    = 4'(WMERGE);
          state_d   = WR_MERGE;
          if (rdc) err_d = 1'b1;
        end else if (rdc) begin
          rd_req_d  = 1'b1;
          rd_addr_d = addr_s2_q;
          rd_hi_d   = ce_hi & ~ce_lo;
          state_d   = RD_ACT;
        end
      end
      RD_ACT: begin
        if (wrc) err_d = 1'b1;
        if (!oe || !cs) state_d = IDLE;
      end
      WR_MERGE: begin
        wr_be_d   = wr_be_q | {we_hi, we_lo};
        wr_data_d = data_s2_q;
        mcnt_d    = mcnt_q - 4'd1;
        // An early release wins over the merge timeout landing in the same cycle.
        if (!we_hi && !we_lo) begin
          wr_req_d = 1'b1;
          state_d  = IDLE;
        end else if (mcnt_q == 4'd1) begin
          wr_req_d = 1'b1;
          state_d  = WR_ACT;
        end
      end
      WR_ACT: begin
        if (!we_hi && !we_lo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_hi_q   <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      mcnt_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      rd_hi_q   <= rd_hi_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      mcnt_q    <= mcnt_d;
      err_q     <= err_d;
    end
  end

  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign rd_hi    = rd_hi_q;
  assign wr_req   = wr_req_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_be    = wr_be_q;
  assign bus_busy = state_q != IDLE;
  assign bus_err  = err_q;

`ifdef MDBUS_STAT_EN
  logic [15:0] stat_rd_q, stat_wr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      if (rd_req_d && stat_rd_q != 16'hFFFF) stat_rd_q <= stat_rd_q + 16'd1;
      if (wr_req_d && stat_wr_q != 16'hFFFF) stat_wr_q <= stat_wr_q + 16'd1;
    end
  end

  assign stat_rd = stat_rd_q;
  assign stat_wr = stat_wr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdbus_front.sv
// ============================================================================
// Module   : tb_mdbus_front
// Purpose  : Directed self-checking bench for mdbus_front (FILT=2; one
//            instance with WMERGE=3, one with WMERGE=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdbus_front;

  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] bus_addr;
  logic [15:0]   bus_data;
  logic          ce_lo_n, ce_hi_n, oe_n, as_n, we_lo_n, we_hi_n;

  logic          a_rd_req, a_rd_hi, a_wr_req, a_bus_busy, a_bus_err;
  logic [AW-1:0] a_rd_addr, a_wr_addr;
  logic [15:0]   a_wr_data;
  logic [1:0]    a_wr_be;
  logic          b_rd_req, b_rd_hi, b_wr_req, b_bus_busy, b_bus_err;
  logic [AW-1:0] b_rd_addr, b_wr_addr;
  logic [15:0]   b_wr_data;
  logic [1:0]    b_wr_be;
`ifdef MDBUS_STAT_EN
  logic [15:0]   a_stat_rd, a_stat_wr, b_stat_rd, b_stat_wr;
`endif

  mdbus_front #(.AW(AW), .FILT(2), .WMERGE(3)) u_dut_a (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data(bus_data),
    .ce_lo_n(ce_lo_n), .ce_hi_n(ce_hi_n), .oe_n(oe_n), .as_n(as_n),
    .we_lo_n(we_lo_n), .we_hi_n(we_hi_n),
    .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_hi(a_rd_hi),
    .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .bus_busy(a_bus_busy), .bus_err(a_bus_err)
`ifdef MDBUS_STAT_EN
    , .stat_rd(a_stat_rd), .stat_wr(a_stat_wr)
`endif
  );

  mdbus_front #(.AW(AW), .FILT(2), .WMERGE(8)) u_dut_b (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_data(bus_data),
    .ce_lo_n(ce_lo_n), .ce_hi_n(ce_hi_n), .oe_n(oe_n), .as_n(as_n),
    .we_lo_n(we_lo_n), .we_hi_n(we_hi_n),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_hi(b_rd_hi),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .bus_busy(b_bus_busy), .bus_err(b_bus_err)
`ifdef MDBUS_STAT_EN
    , .stat_rd(b_stat_rd), .stat_wr(b_stat_wr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse bookkeeping, refreshed one step after every rising edge.
  int            t;
  int            a_rd_n, a_wr_n, b_wr_n;
  int            a_rd_first, a_wr_first, b_wr_first;
  logic          a_rd_prev = 1'b0, a_wr_prev = 1'b0, b_wr_prev = 1'b0;
  logic          dbl = 1'b0;
  logic          busy_seen;
  logic [AW-1:0] cap_rd_addr, cap_wr_addr;
  logic          cap_rd_hi, cap_rd_busy, b_cap_busy;
  logic [15:0]   cap_wr_data, b_cap_data;
  logic [1:0]    cap_wr_be, b_cap_be;

  task automatic clr();
    t = 0; a_rd_n = 0; a_wr_n = 0; b_wr_n = 0;
    a_rd_first = 0; a_wr_first = 0; b_wr_first = 0;
    busy_seen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
    if (a_rd_req) begin
      a_rd_n++;
      if (a_rd_first == 0) a_rd_first = t;
      cap_rd_addr = a_rd_addr; cap_rd_hi = a_rd_hi; cap_rd_busy = a_bus_busy;
    end
    if (a_wr_req) begin
      a_wr_n++;
      if (a_wr_first == 0) a_wr_first = t;
      cap_wr_addr = a_wr_addr; cap_wr_data = a_wr_data; cap_wr_be = a_wr_be;
    end
    if (b_wr_req) begin
      b_wr_n++;
      if (b_wr_first == 0) b_wr_first = t;
      b_cap_data = b_wr_data; b_cap_be = b_wr_be; b_cap_busy = b_bus_busy;
    end
    if ((a_rd_req && a_rd_prev) || (a_wr_req && a_wr_prev) || (b_wr_req && b_wr_prev)) dbl = 1'b1;
    a_rd_prev = a_rd_req; a_wr_prev = a_wr_req; b_wr_prev = b_wr_req;
    if (a_bus_busy) busy_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; bus_addr = '0; bus_data = '0;
    ce_lo_n = 1'b1; ce_hi_n = 1'b1; oe_n = 1'b1; as_n = 1'b1; we_lo_n = 1'b1; we_hi_n = 1'b1;
    clr();
    ticks(3);
    check("rst_rd_req",  32'(a_rd_req),   32'd0);
    check("rst_wr_req",  32'(a_wr_req),   32'd0);
    check("rst_busy",    32'(a_bus_busy), 32'd0);
    check("rst_err",     32'(a_bus_err),  32'd0);
    check("rst_rd_addr", 32'(a_rd_addr),  32'd0);
    check("rst_wr_be",   32'(a_wr_be),    32'd0);
    rst = 1'b0;
    ticks(2);

    // Read from the low cart area
    ce_lo_n = 1'b0; bus_addr = 23'h012345;
    tick();
    clr();
    oe_n = 1'b0;
    ticks(10);
    check("rd_count",   32'(a_rd_n),      32'd1);
    check("rd_latency", 32'(a_rd_first),  32'd4);
    check("rd_addr",    32'(cap_rd_addr), 32'h012345);
    check("rd_hi",      32'(cap_rd_hi),   32'd0);
    check("rd_busy",    32'(cap_rd_busy), 32'd1);
    check("rd_no_wr",   32'(a_wr_n),      32'd0);
    oe_n = 1'b1;
    ticks(3);
    check("rd_busy_hold", 32'(a_bus_busy), 32'd1);
    tick();
    check("rd_busy_drop", 32'(a_bus_busy), 32'd0);
    ce_lo_n = 1'b1;
    ticks(4);

    // One-cycle oe glitch
    ce_lo_n = 1'b0;
    ticks(4);
    clr();
    oe_n = 1'b0;
    tick();
    oe_n = 1'b1;
    ticks(6);
    check("glitch_rd",   32'(a_rd_n),    32'd0);
    check("glitch_busy", 32'(busy_seen), 32'd0);
    ce_lo_n = 1'b1;
    ticks(4);

    // Two-lane write merge
    bus_addr = 23'h00ABCD; bus_data = 16'hBEEF;
    as_n = 1'b0; we_hi_n = 1'b0;
    clr();
    ticks(2);
    we_lo_n = 1'b0;
    ticks(8);
    check("mrg_count",   32'(a_wr_n),      32'd1);
    check("mrg_latency", 32'(a_wr_first),  32'd7);
    check("mrg_be",      32'(cap_wr_be),   32'd3);
    check("mrg_data",    32'(cap_wr_data), 32'hBEEF);
    check("mrg_addr",    32'(cap_wr_addr), 32'h00ABCD);
    check("mrg_no_rd",   32'(a_rd_n),      32'd0);
    as_n = 1'b1; we_hi_n = 1'b1; we_lo_n = 1'b1;
    ticks(6);
    check("mrg_idle",    32'(a_bus_busy),  32'd0);
    check("mrg_single",  32'(a_wr_n),      32'd1);

    // Short low-lane write on the WMERGE=8 instance
    bus_addr = 23'h000100; bus_data = 16'h1234;
    as_n = 1'b0; we_lo_n = 1'b0;
    clr();
    ticks(3);
    as_n = 1'b1; we_lo_n = 1'b1;
    ticks(8);
    check("short_count",   32'(b_wr_n),     32'd1);
    check("short_latency", 32'(b_wr_first), 32'd7);
    check("short_be",      32'(b_cap_be),   32'd1);
    check("short_data",    32'(b_cap_data), 32'h1234);
    check("short_idle",    32'(b_cap_busy), 32'd0);

    // Read/write conflict
    ce_lo_n = 1'b0;
    ticks(4);
    clr();
    oe_n = 1'b0; we_lo_n = 1'b0; as_n = 1'b0;
    ticks(8);
    check("cfl_no_rd", 32'(a_rd_n),    32'd0);
    check("cfl_wr",    32'(a_wr_n),    32'd1);
    check("cfl_err",   32'(a_bus_err), 32'd1);
    oe_n = 1'b1; we_lo_n = 1'b1; as_n = 1'b1; ce_lo_n = 1'b1;
    ticks(8);
    check("cfl_err_sticky", 32'(a_bus_err), 32'd1);
    check("cfl_no_rd_late", 32'(a_rd_n),    32'd0);

    // Reset during WR_MERGE, strobe held through release
    as_n = 1'b0; we_lo_n = 1'b0;
    clr();
    ticks(4);
    check("abort_merging", 32'(a_bus_busy), 32'd1);
    check("abort_no_wr_yet", 32'(a_wr_n),   32'd0);
    rst = 1'b1;
    tick();
    check("abort_wr_req",  32'(a_wr_req),   32'd0);
    check("abort_busy",    32'(a_bus_busy), 32'd0);
    check("abort_err",     32'(a_bus_err),  32'd0);
    check("abort_wr_be",   32'(a_wr_be),    32'd0);
    check("abort_wr_data", 32'(a_wr_data),  32'd0);
    check("abort_rd_addr", 32'(a_rd_addr),  32'd0);
    check("abort_no_pulse", 32'(a_wr_n),    32'd0);
    rst = 1'b0;
    clr();
    ticks(10);
    check("abort_fresh_count",   32'(a_wr_n),     32'd1);
    check("abort_fresh_latency", 32'(a_wr_first), 32'd7);
`ifdef MDBUS_STAT_EN
    check("stat_wr", 32'(a_stat_wr), 32'd1);
    check("stat_rd", 32'(a_stat_rd), 32'd0);
`endif
    as_n = 1'b1; we_lo_n = 1'b1;
    ticks(8);
    check("pulse_width", 32'(dbl), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
